// File: rtl/cache_block_directly_mapped.sv
// Read-only direct-mapped cache between a word requester and a block-wide backing memory.
// Hits return the word one cycle after acceptance; misses refill a whole line through a valid/ready port.
//
// state | meaning
// IDLE  | tag lookup; hits accepted back-to-back, a miss captures the address
// REQ   | block refill request held on addr_out until addr_out_ready
// FILL  | refill block present on data_in; line written, word forwarded
module cache_block_directly_mapped #(
  parameter int DWIDTH           = 32,
  parameter int CACHE_WIDTH_BITS = 4,
  parameter int BLOCK_WIDTH_BITS = 4,
  parameter int ADDR_IN_WIDTH    = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      addr_in_valid,
  input  logic [ADDR_IN_WIDTH-1:0]                  addr_in,
  output logic                                      addr_in_ready,
  output logic [DWIDTH-1:0]                         data_out,
  output logic                                      addr_out_valid,
  output logic [ADDR_IN_WIDTH-BLOCK_WIDTH_BITS-1:0] addr_out,
  input  logic                                      addr_out_ready,
  input  logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]   data_in
);

  localparam int TAG_W = ADDR_IN_WIDTH - CACHE_WIDTH_BITS - BLOCK_WIDTH_BITS;
  localparam int LINES = 2 ** CACHE_WIDTH_BITS;
  localparam int WORDS = 2 ** BLOCK_WIDTH_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]                   state;
  logic [1:0]                   state_nxt;
  logic [LINES-1:0]             line_valid;
  logic [TAG_W-1:0]             tag_mem  [LINES];
  logic [WORDS-1:0][DWIDTH-1:0] data_mem [LINES];
  logic [ADDR_IN_WIDTH-1:0]     miss_addr;
  logic [DWIDTH-1:0]            data_out_q;

  logic [BLOCK_WIDTH_BITS-1:0]  in_off;
  logic [CACHE_WIDTH_BITS-1:0]  in_idx;
  logic [TAG_W-1:0]             in_tag;
  logic [BLOCK_WIDTH_BITS-1:0]  miss_off;
  logic [CACHE_WIDTH_BITS-1:0]  miss_idx;
  logic [TAG_W-1:0]             miss_tag;
  logic                         lookup_hit;
  logic                         miss_detect;
  logic [WORDS-1:0][DWIDTH-1:0] fill_block;
  logic [DWIDTH-1:0]            fill_word;

  assign in_off   = addr_in[BLOCK_WIDTH_BITS-1:0];
  assign in_idx   = addr_in[BLOCK_WIDTH_BITS +: CACHE_WIDTH_BITS];
  assign in_tag   = addr_in[ADDR_IN_WIDTH-1 -: TAG_W];
  assign miss_off = miss_addr[BLOCK_WIDTH_BITS-1:0];
  assign miss_idx = miss_addr[BLOCK_WIDTH_BITS +: CACHE_WIDTH_BITS];
  assign miss_tag = miss_addr[ADDR_IN_WIDTH-1 -: TAG_W];

  assign lookup_hit  = line_valid[in_idx] && (tag_mem[in_idx] == in_tag);
  assign miss_detect = (state == S_IDLE) && addr_in_valid && !lookup_hit;

  assign fill_block = data_in;
  assign fill_word  = fill_block[miss_off];

  always_comb begin
    state_nxt     = state;
    addr_in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        addr_in_ready = addr_in_valid && lookup_hit;
        if (miss_detect) state_nxt = S_REQ;
      end
      S_REQ: begin
        // The word request completes with the refill handshake; data follows in FILL.
        addr_in_ready = addr_out_ready;
        if (addr_out_ready) state_nxt = S_FILL;
      end
      S_FILL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (rst) addr_in_ready = 1'b0;
  end

  assign addr_out_valid = (state == S_REQ);
  assign addr_out       = miss_addr[ADDR_IN_WIDTH-1:BLOCK_WIDTH_BITS];
  assign data_out       = (state == S_FILL) ? fill_word : data_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      line_valid <= '0;
      miss_addr  <= '0;
      data_out_q <= '0;
    end else begin
      state <= state_nxt;
      if (miss_detect) miss_addr <= addr_in;
      if ((state == S_IDLE) && addr_in_ready) data_out_q <= data_mem[in_idx][in_off];
      if (state == S_FILL) begin
        data_out_q           <= fill_word;
        line_valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; line_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_FILL)) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= fill_block;
    end
  end

endmodule

// File: tb/tb_cache_block_directly_mapped.sv
// Directed bench for cache_block_directly_mapped: handshake checks inline,
// returned words checked by a scoreboard monitor one cycle after each acceptance.
module tb_cache_block_directly_mapped;

  logic        clk;
  logic        rst;
  logic        addr_in_valid;
  logic [15:0] addr_in;
  logic        addr_in_ready;
  logic [3:0]  data_out;
  logic        addr_out_valid;
  logic [11:0] addr_out;
  logic        addr_out_ready;
  logic [63:0] data_in;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];
  bit acc_prev = 1'b0;

  cache_block_directly_mapped #(
    .DWIDTH(4), .CACHE_WIDTH_BITS(4), .BLOCK_WIDTH_BITS(4), .ADDR_IN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_in_valid(addr_in_valid), .addr_in(addr_in), .addr_in_ready(addr_in_ready),
    .data_out(data_out),
    .addr_out_valid(addr_out_valid), .addr_out(addr_out), .addr_out_ready(addr_out_ready),
    .data_in(data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data for any accepted request must appear in the following cycle.
  always @(negedge clk) begin
    if (acc_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_out_unexpected: got %0h expected none", data_out);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out: got %0h expected %0h", data_out, e);
        end
      end
    end
    acc_prev = addr_in_valid && addr_in_ready && !rst;
  end

  // Leaves addr_in_valid high so consecutive calls stream back-to-back.
  task automatic do_hit(input logic [15:0] a, input logic [3:0] expd);
    addr_in       = a;
    addr_in_valid = 1'b1;
    @(negedge clk);
    chk("hit_ready", addr_in_ready, 1);
    chk("hit_aov", addr_out_valid, 0);
    exp_q.push_back(expd);
    @(posedge clk); #1;
  endtask

  task automatic do_miss(input logic [15:0] a, input logic [11:0] blk,
                         input logic [63:0] block, input logic [3:0] expd, input int waits);
    addr_in       = a;
    addr_in_valid = 1'b1;
    @(negedge clk);
    chk("miss_detect_ready", addr_in_ready, 0);
    chk("miss_detect_aov", addr_out_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("req_aov", addr_out_valid, 1);
      chk("req_addr_out", addr_out, blk);
      chk("req_ready", addr_in_ready, 0);
      @(posedge clk); #1;
    end
    addr_out_ready = 1'b1;
    @(negedge clk);
    chk("hs_aov", addr_out_valid, 1);
    chk("hs_addr_out", addr_out, blk);
    chk("hs_ready", addr_in_ready, 1);
    exp_q.push_back(expd);
    @(posedge clk); #1;
    addr_out_ready = 1'b0;
    addr_in_valid  = 1'b0;
    data_in        = block;
    @(negedge clk);
    chk("fill_aov", addr_out_valid, 0);
    chk("fill_ready", addr_in_ready, 0);
    @(posedge clk); #1;
    data_in = '0;
  endtask

  initial begin
    rst            = 1'b1;
    addr_in_valid  = 1'b0;
    addr_in        = '0;
    addr_out_ready = 1'b0;
    data_in        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", addr_in_ready, 0);
    chk("reset_aov", addr_out_valid, 0);
    chk("reset_data_out", data_out, 0);
    repeat (30) @(posedge clk);
    #1;

    do_miss(16'hEAD0, 12'hEAD, 64'hAAAA_AAAA_AAAA_AAAF, 4'hF, 2);
    for (int i = 0; i < 16; i++)
      do_hit(16'hEAD0 + 16'(i), (i == 0) ? 4'hF : 4'hA);
    addr_in_valid = 1'b0;
    @(posedge clk); #1;

    do_miss(16'hEAE0, 12'hEAE, 64'hBBBB_BBBB_BBBB_BBBB, 4'hB, 1);
    for (int i = 0; i < 16; i++)
      do_hit(16'hEAE0 + 16'(i), 4'hB);
    addr_in_valid = 1'b0;
    @(posedge clk); #1;

    do_miss(16'hEBD0, 12'hEBD, 64'h2B2B_2B2B_2B2B_2B2B, 4'hB, 3);
    do_hit(16'hEBD3, 4'h2);
    do_hit(16'hEBD8, 4'hB);
    addr_in_valid = 1'b0;
    @(posedge clk); #1;

    // Stream a full line with addr_in_valid held high throughout.
    for (int i = 0; i < 16; i++)
      do_hit(16'hEBD0 + 16'(i), (i % 2 == 0) ? 4'hB : 4'h2);
    addr_in_valid = 1'b0;
    @(posedge clk); #1;

    // 0xEAD0 was evicted by the conflict; abandon its refill with a reset.
    addr_in       = 16'hEAD0;
    addr_in_valid = 1'b1;
    @(negedge clk);
    chk("evicted_ready", addr_in_ready, 0);
    chk("evicted_aov", addr_out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("evicted_req_aov", addr_out_valid, 1);
    chk("evicted_req_addr", addr_out, 12'hEAD);
    @(posedge clk); #1;
    rst           = 1'b1;
    addr_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_cycle_ready", addr_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_aov", addr_out_valid, 0);
    chk("post_rst_data_out", data_out, 0);
    @(posedge clk); #1;

    do_miss(16'hEBD0, 12'hEBD, 64'hCCCC_CCCC_CCCC_CCCC, 4'hC, 0);
    do_hit(16'hEBD5, 4'hC);
    addr_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
